fft_sample_buffer: RTL

FFT_SAMPLE_BUFFER -- requirements
Module: fft_sample_buffer

---
 rtl/fft_sample_buffer_if.sv | 45 ++++
 rtl/fft_sample_buffer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fft_sample_buffer_if.sv
// Bundle of stream, engine and status signals between the FFT sample buffer
// (slave modport) and its surroundings (master modport).
interface fft_sample_buffer_if #(
   parameter int BIT_WIDTH = 8,
   parameter int FFT_SIZE  = 16,
   parameter int MODE_NUM  = 3
);
   localparam int AW = $clog2(FFT_SIZE);
   localparam int MW = (MODE_NUM > 1) ? $clog2(MODE_NUM) : 1;
   localparam int DW = 2 * BIT_WIDTH;

   logic          start;
   logic [MW-1:0] mode;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          eng_rst;
   logic          eng_init;
   logic [MW-1:0] eng_mode;
   logic [AW-1:0] eng_addr;
   logic          eng_wr_en;
   logic [DW-1:0] eng_wr_data;
   logic [DW-1:0] eng_rd_data;
   logic          eng_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          done;
   logic          err;

   modport slave (
      input  start, mode, in_data, in_valid, eng_addr, eng_wr_en, eng_wr_data,
             eng_ready, out_ready,
      output in_ready, eng_rst, eng_init, eng_mode, eng_rd_data, out_data,
             out_valid, busy, done, err
   );

   modport master (
      output start, mode, in_data, in_valid, eng_addr, eng_wr_en, eng_wr_data,
             eng_ready, out_ready,
      input  in_ready, eng_rst, eng_init, eng_mode, eng_rd_data, out_data,
             out_valid, busy, done, err
   );
endinterface

// File: rtl/fft_sample_buffer.sv
// Sample buffer around an in-place FFT engine: bit-reversed load, engine access, natural-order unload.
// Optional RUN watchdog enabled by defining FFT_BUF_WDOG_EN.
module fft_sample_buffer #(
   parameter int BIT_WIDTH = 8,
   parameter int FFT_SIZE  = 16,
   parameter int MODE_NUM  = 3
) (
   input logic                clk,
   input logic                rst,
   fft_sample_buffer_if.slave bus
);
   localparam int AW = $clog2(FFT_SIZE);
   localparam int MW = (MODE_NUM > 1) ? $clog2(MODE_NUM) : 1;
   localparam int DW = 2 * BIT_WIDTH;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [MW-1:0] mode_q, mode_d;
   logic          run_first_q, run_first_d;
   logic          done_q, done_d;

   logic [DW-1:0] mem [FFT_SIZE];

   logic [AW-1:0] last_cnt;
   logic [AW-1:0] rev_addr;
   logic [MW-1:0] mode_clamped;
   logic          in_fire;
   logic          out_fire;
   logic          eng_wr_fire;
   logic          cnt_last;
   logic          wdog_expire;

   // One bit-reversal network per transform size; the latched mode picks one.
   logic [MODE_NUM-1:0][AW-1:0] rev_by_mode;

   generate
      for (genvar gi = 0; gi < MODE_NUM; gi++) begin : g_rev
         localparam int W = (2 + gi < AW) ? 2 + gi : AW;
         for (genvar gb = 0; gb < W; gb++) begin : g_bit
            assign rev_by_mode[gi][gb] = cnt_q[W-1-gb];
         end
         if (W < AW) begin : g_pad
            assign rev_by_mode[gi][AW-1:W] = '0;
         end
      end
   endgenerate

   assign rev_addr     = rev_by_mode[mode_q];
   assign last_cnt     = AW'((32'd4 << mode_q) - 32'd1);
   assign cnt_last     = (cnt_q == last_cnt);
   assign mode_clamped = (int'(bus.mode) >= MODE_NUM) ? MW'(MODE_NUM - 1) : bus.mode;

   assign in_fire     = (state_q == LOAD) && bus.in_valid;
   assign out_fire    = (state_q == UNLOAD) && bus.out_ready;
   assign eng_wr_fire = (state_q == RUN) && bus.eng_wr_en;

`ifdef FFT_BUF_WDOG_EN
   logic [7:0] wdog_q;
   logic       err_q;

   // Counter sits at zero outside RUN, so it is already clear on RUN entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= (state_q == RUN) ? wdog_q + 8'd1 : 8'd0;
         err_q  <= wdog_expire;
      end
   end

   assign wdog_expire = (state_q == RUN) && (wdog_q == 8'hFF) && !bus.eng_ready;
   assign bus.err     = err_q;
`else
   assign wdog_expire = 1'b0;
   assign bus.err     = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mode_q      <= '0;
         run_first_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         run_first_q <= run_first_d;
         done_q      <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      run_first_d = 1'b0;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = LOAD;
               cnt_d   = '0;
               mode_d  = mode_clamped;
            end
         end
         LOAD: begin
            if (in_fire) begin
               if (cnt_last) begin
                  state_d     = RUN;
                  cnt_d       = '0;
                  run_first_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + AW'(1);
               end
            end
         end
         RUN: begin
            if (bus.eng_ready) begin
               state_d = UNLOAD;
               cnt_d   = '0;
            end else if (wdog_expire) begin
               state_d = IDLE;
            end
         end
         UNLOAD: begin
            if (out_fire) begin
               if (cnt_last) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + AW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.in_ready  = (state_q == LOAD);
      bus.out_valid = (state_q == UNLOAD);
      bus.eng_rst   = (state_q != RUN);
      bus.eng_init  = (state_q == RUN) && run_first_q;
      bus.busy      = (state_q != IDLE);
   end

   assign bus.done     = done_q;
   assign bus.eng_mode = mode_q;

   // Sample memory; load and engine writes live in mutually exclusive states.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         mem[rev_addr] <= bus.in_data;
      end else if (eng_wr_fire) begin
         mem[bus.eng_addr] <= bus.eng_wr_data;
      end
   end

   assign bus.eng_rd_data = mem[bus.eng_addr];
   assign bus.out_data    = mem[cnt_q];

endmodule
